microbot_maneuver_sequencer: RTL and testbench

Timed motion controller for the microbot H-bridge motor outputs. It replaces purely reactive sensor-to-motor mapping with sequenced maneuvers: forward, back-off, then turn, and forward again. It inserts dead-time on every drive-direction change to protect the H-bridge. Debounced sensors feed the sequencer, and a retry limit latches a fault when the robot is boxed in. It sits between the ui_in sensor pins and the uo_out motor nibble.

---
 rtl/microbot_pkg.sv | 31 +++
 rtl/microbot_sensor_debounce.sv | 38 +++
 rtl/microbot_maneuver_sequencer.sv | 141 ++++++++++++++
 tb/tb_microbot_maneuver_sequencer.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/microbot_pkg.sv
// Shared types for the microbot maneuver sequencer: state encoding and H-bridge motor nibbles.
package microbot_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FORWARD  = 3'd1,
        S_DEADTIME = 3'd2,
        S_BACKUP   = 3'd3,
        S_TURN_L   = 3'd4,
        S_TURN_R   = 3'd5,
        S_FAULT    = 3'd6
    } state_t;

    // Nibble order {motorA_d, motorA_i, motorB_d, motorB_i}
    localparam logic [3:0] MOT_OFF = 4'b0000;
    localparam logic [3:0] MOT_FWD = 4'b1010;
    localparam logic [3:0] MOT_REV = 4'b0101;
    localparam logic [3:0] MOT_TR  = 4'b1001;
    localparam logic [3:0] MOT_TL  = 4'b0110;

    function automatic logic [3:0] motor_code(input state_t s);
        case (s)
            S_FORWARD: motor_code = MOT_FWD;
            S_BACKUP:  motor_code = MOT_REV;
            S_TURN_R:  motor_code = MOT_TR;
            S_TURN_L:  motor_code = MOT_TL;
            default:   motor_code = MOT_OFF;
        endcase
    endfunction

endpackage

// File: rtl/microbot_sensor_debounce.sv
// Two-flop synchronizer followed by a consecutive-sample debouncer for one raw sensor pin.
module microbot_sensor_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic db
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync_p0;
    logic          sync_p1;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            cnt     <= '0;
            db      <= 1'b0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            // Any sample agreeing with the current output restarts the count
            if (sync_p1 == db) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                db  <= sync_p1;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/microbot_maneuver_sequencer.sv
// Timed maneuver FSM driving the H-bridge nibble: forward, back-off, turn, with dead-time
// between drive directions and a retry limit that latches a fault when boxed in.
module microbot_maneuver_sequencer
    import microbot_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DEADTIME_CYCLES = 8,
    parameter int BACKUP_CYCLES   = 64,
    parameter int TURN_CYCLES     = 32,
    parameter int PROGRESS_CYCLES = 16,
    parameter int MAX_RETRIES     = 3,
    parameter int CNT_W           = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       f_sensor,
    input  logic       l_sensor,
    input  logic       r_sensor,
    output logic [3:0] motors,
    output logic [2:0] state_o,
    output logic       fault,
    output logic [1:0] retry_cnt
);

    localparam logic [CNT_W-1:0] DT_LAST   = CNT_W'(DEADTIME_CYCLES - 1);
    localparam logic [CNT_W-1:0] BK_LAST   = CNT_W'(BACKUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN_CYCLES - 1);
    localparam logic [CNT_W-1:0] PROG_LAST = CNT_W'(PROGRESS_CYCLES - 1);
    localparam logic [1:0]       RETRY_MAX = 2'(MAX_RETRIES);

    logic f_db, l_db, r_db;

    microbot_sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_f (
        .clk(clk), .reset(reset), .raw(f_sensor), .db(f_db)
    );
    microbot_sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_l (
        .clk(clk), .reset(reset), .raw(l_sensor), .db(l_db)
    );
    microbot_sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_r (
        .clk(clk), .reset(reset), .raw(r_sensor), .db(r_db)
    );

    state_t             state, state_n;
    state_t             pending, pending_n;
    logic [CNT_W-1:0]   dwell, dwell_n;
    logic [1:0]         retry_n;
    logic [1:0]         retry_inc;
    state_t             backup_target;

    // Entering BACKUP consumes a retry; the attempt that reaches the limit faults instead
    assign retry_inc     = (retry_cnt == RETRY_MAX) ? retry_cnt : retry_cnt + 2'd1;
    assign backup_target = (retry_inc == RETRY_MAX) ? S_FAULT : S_BACKUP;

    always_comb begin
        state_n   = state;
        pending_n = pending;
        retry_n   = retry_cnt;
        if (state == S_FAULT) begin
            if (!enable) begin
                state_n = S_IDLE;
                retry_n = '0;
            end
        end else if (!enable) begin
            state_n   = S_IDLE;
            pending_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (f_db) begin
                        state_n = backup_target;
                        retry_n = retry_inc;
                    end else begin
                        state_n = S_FORWARD;
                    end
                end
                S_FORWARD: begin
                    if (f_db) begin
                        state_n   = S_DEADTIME;
                        pending_n = S_BACKUP;
                    end else if (dwell == PROG_LAST) begin
                        retry_n = '0;
                    end
                end
                S_BACKUP: begin
                    if (dwell == BK_LAST) begin
                        state_n   = S_DEADTIME;
                        pending_n = (!l_db && r_db) ? S_TURN_L : S_TURN_R;
                    end
                end
                S_TURN_L, S_TURN_R: begin
                    if (dwell == TURN_LAST) begin
                        state_n   = S_DEADTIME;
                        pending_n = S_FORWARD;
                    end
                end
                S_DEADTIME: begin
                    if (dwell == DT_LAST) begin
                        if (pending == S_BACKUP) begin
                            state_n = backup_target;
                            retry_n = retry_inc;
                        end else begin
                            state_n = pending;
                        end
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end

        // Dwell restarts on every state change and saturates while a state is held
        if ((state_n != state) || !enable) begin
            dwell_n = '0;
        end else if (dwell != '1) begin
            dwell_n = dwell + CNT_W'(1);
        end else begin
            dwell_n = dwell;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            pending   <= S_IDLE;
            dwell     <= '0;
            retry_cnt <= '0;
            motors    <= MOT_OFF;
            fault     <= 1'b0;
        end else begin
            state     <= state_n;
            pending   <= pending_n;
            dwell     <= dwell_n;
            retry_cnt <= retry_n;
            motors    <= motor_code(state_n);
            fault     <= (state_n == S_FAULT);
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_microbot_maneuver_sequencer.sv
// Directed bench for the maneuver sequencer: stimulus queues per-cycle expectations, a monitor checks them.
module tb_microbot_maneuver_sequencer;

    localparam logic [3:0] OFF = 4'b0000;
    localparam logic [3:0] FWD = 4'b1010;
    localparam logic [3:0] REV = 4'b0101;
    localparam logic [3:0] TR  = 4'b1001;
    localparam logic [3:0] TL  = 4'b0110;

    logic       clk = 1'b0;
    logic       reset, enable, f_sensor, l_sensor, r_sensor;
    logic [3:0] motors;
    logic [2:0] state_o;
    logic       fault;
    logic [1:0] retry_cnt;

    microbot_maneuver_sequencer #(
        .DEBOUNCE_CYCLES(2), .DEADTIME_CYCLES(3), .BACKUP_CYCLES(5),
        .TURN_CYCLES(4), .PROGRESS_CYCLES(6), .MAX_RETRIES(3), .CNT_W(8)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .f_sensor(f_sensor), .l_sensor(l_sensor), .r_sensor(r_sensor),
        .motors(motors), .state_o(state_o), .fault(fault), .retry_cnt(retry_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] m;
        logic [2:0] s;
        logic       f;
        logic [1:0] r;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    string cur_tag;
    int    checks   = 0;
    int    failures = 0;
    exp_t  mon_e;
    string mon_t;

    // Expected outputs after the next active edge, given the inputs currently driven
    task automatic cyc(input logic [3:0] m, input logic [2:0] s, input logic f, input logic [1:0] r);
        exp_t e;
        @(posedge clk);
        #1;
        e.m = m; e.s = s; e.f = f; e.r = r;
        exp_q.push_back(e);
        tag_q.push_back(cur_tag);
    endtask

    task automatic run(input int n, input logic [3:0] m, input logic [2:0] s, input logic f,
                       input logic [1:0] r);
        for (int i = 0; i < n; i++) cyc(m, s, f, r);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_t = tag_q.pop_front();
            checks++;
            if ({motors, state_o, fault, retry_cnt} !== mon_e) begin
                failures++;
                $display("FAIL %s: got motors=%b state=%0d fault=%b retry=%0d, want motors=%b state=%0d fault=%b retry=%0d",
                         mon_t, motors, state_o, fault, retry_cnt, mon_e.m, mon_e.s, mon_e.f, mon_e.r);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; enable = 1'b0; f_sensor = 1'b0; l_sensor = 1'b0; r_sensor = 1'b0;
        cur_tag = "reset";        run(2, OFF, 3'd0, 1'b0, 2'd0);

        reset = 1'b0; enable = 1'b1;
        cur_tag = "start_fwd";    run(3, FWD, 3'd1, 1'b0, 2'd0);

        cur_tag = "glitch";       f_sensor = 1'b1; cyc(FWD, 3'd1, 1'b0, 2'd0);
        f_sensor = 1'b0;          run(5, FWD, 3'd1, 1'b0, 2'd0);

        // Obstacle front and right: back off, then turn left
        cur_tag = "f_latency";    f_sensor = 1'b1; r_sensor = 1'b1; run(4, FWD, 3'd1, 1'b0, 2'd0);
        cur_tag = "dt_to_back1";  run(3, OFF, 3'd2, 1'b0, 2'd0);
        cur_tag = "backup1";      cyc(REV, 3'd3, 1'b0, 2'd1);
        f_sensor = 1'b0;          run(4, REV, 3'd3, 1'b0, 2'd1);
        cur_tag = "dt_to_turnl";  run(3, OFF, 3'd2, 1'b0, 2'd1);
        cur_tag = "turn_l";       run(4, TL,  3'd4, 1'b0, 2'd1);
        cur_tag = "dt_to_fwd1";   run(3, OFF, 3'd2, 1'b0, 2'd1);
        cur_tag = "fwd_after_tl"; cyc(FWD, 3'd1, 1'b0, 2'd1);

        // Obstacle front and left: back off, then turn right
        cur_tag = "f_latency2";   f_sensor = 1'b1; l_sensor = 1'b1; r_sensor = 1'b0;
        run(4, FWD, 3'd1, 1'b0, 2'd1);
        cur_tag = "dt_to_back2";  run(3, OFF, 3'd2, 1'b0, 2'd1);
        cur_tag = "backup2";      cyc(REV, 3'd3, 1'b0, 2'd2);
        f_sensor = 1'b0;          run(4, REV, 3'd3, 1'b0, 2'd2);
        cur_tag = "dt_to_turnr";  run(3, OFF, 3'd2, 1'b0, 2'd2);
        cur_tag = "turn_r";       run(4, TR,  3'd5, 1'b0, 2'd2);
        cur_tag = "dt_to_fwd2";   run(3, OFF, 3'd2, 1'b0, 2'd2);

        // Six clear FORWARD cycles count as progress
        cur_tag = "fwd_progress"; run(6, FWD, 3'd1, 1'b0, 2'd2);
        cur_tag = "retry_clear";  cyc(FWD, 3'd1, 1'b0, 2'd0);

        // Boxed in: front obstacle held permanently
        cur_tag = "box_fwd";      f_sensor = 1'b1; l_sensor = 1'b0; run(4, FWD, 3'd1, 1'b0, 2'd0);
        cur_tag = "box_dt1";      run(3, OFF, 3'd2, 1'b0, 2'd0);
        cur_tag = "box_back1";    run(5, REV, 3'd3, 1'b0, 2'd1);
        cur_tag = "box_dt2";      run(3, OFF, 3'd2, 1'b0, 2'd1);
        cur_tag = "box_turn1";    run(4, TR,  3'd5, 1'b0, 2'd1);
        cur_tag = "box_dt3";      run(3, OFF, 3'd2, 1'b0, 2'd1);
        cur_tag = "box_fwd1";     cyc(FWD, 3'd1, 1'b0, 2'd1);
        cur_tag = "box_dt4";      run(3, OFF, 3'd2, 1'b0, 2'd1);
        cur_tag = "box_back2";    run(5, REV, 3'd3, 1'b0, 2'd2);
        cur_tag = "box_dt5";      run(3, OFF, 3'd2, 1'b0, 2'd2);
        cur_tag = "box_turn2";    run(4, TR,  3'd5, 1'b0, 2'd2);
        cur_tag = "box_dt6";      run(3, OFF, 3'd2, 1'b0, 2'd2);
        cur_tag = "box_fwd2";     cyc(FWD, 3'd1, 1'b0, 2'd2);
        cur_tag = "box_dt7";      run(3, OFF, 3'd2, 1'b0, 2'd2);
        cur_tag = "fault_hold";   run(4, OFF, 3'd6, 1'b1, 2'd3);
        cur_tag = "fault_exit";   enable = 1'b0; run(2, OFF, 3'd0, 1'b0, 2'd0);

        // Direct IDLE->BACKUP, then enable dropped mid-BACKUP
        cur_tag = "idle_backup";  enable = 1'b1; run(2, REV, 3'd3, 1'b0, 2'd1);
        cur_tag = "en_drop";      enable = 1'b0; run(2, OFF, 3'd0, 1'b0, 2'd1);
        cur_tag = "reen_backup";  enable = 1'b1; cyc(REV, 3'd3, 1'b0, 2'd2);
        f_sensor = 1'b0;          run(4, REV, 3'd3, 1'b0, 2'd2);
        cur_tag = "dt_pre_reset"; cyc(OFF, 3'd2, 1'b0, 2'd2);
        cur_tag = "mid_reset";    reset = 1'b1; cyc(OFF, 3'd0, 1'b0, 2'd0);
        cur_tag = "post_reset";   reset = 1'b0; run(3, FWD, 3'd1, 1'b0, 2'd0);

        @(negedge clk);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
